// File: rtl/barrett_reducer_pipe.sv
// Three-stage pipelined Barrett reducer: maps an IN_W-bit operand to a mod Q, optionally negated,
// with a pass-through tag. All stages shift together on a single advance strobe.
module barrett_reducer_pipe #(
    parameter int unsigned Q     = 12289,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 14,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  a_i,
    input  logic             neg_i,
    input  logic [TAG_W-1:0] tag_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] result_o,
    output logic [TAG_W-1:0] tag_out_o,
    output logic             out_neg_o
);

    localparam int unsigned K   = IN_W;
    localparam int unsigned KW  = K + 1;
    localparam int unsigned QEW = IN_W + 1;
    localparam int unsigned RW  = OUT_W + 2;
    localparam int unsigned XW  = IN_W + RW;
    localparam int unsigned PW  = IN_W + K + 1;

    localparam logic [K:0]    Pow2K = {1'b1, {K{1'b0}}};
    localparam logic [K:0]    M     = Pow2K / KW'(Q);
    localparam logic [XW-1:0] QX    = XW'(Q);
    localparam logic [RW-1:0] QR    = RW'(Q);
    localparam logic [RW-1:0] Q2R   = RW'(2 * Q);

    if (Q <= 2) begin : g_q_too_small
        $error("barrett_reducer_pipe: Q must be greater than 2");
    end
    if (64'(Q) >= (64'd1 << OUT_W)) begin : g_q_too_large
        $error("barrett_reducer_pipe: Q must be below 2**OUT_W");
    end
    if (IN_W < OUT_W) begin : g_in_w_too_small
        $error("barrett_reducer_pipe: IN_W must be at least OUT_W");
    end

    logic v1_q, v2_q, v3_q;
    logic adv;

    assign adv         = en_i & (~v3_q | out_ready_i);
    assign in_ready_o  = adv;
    assign out_valid_o = v3_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Stage 1: quotient estimate qe = floor(a * M / 2^K).
    logic [IN_W-1:0]  a1_q;
    logic [QEW-1:0]   qe1_d, qe1_q;
    logic             neg1_q;
    logic [TAG_W-1:0] tag1_q;

    assign qe1_d = QEW'((PW'(a_i) * PW'(M)) >> K);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a1_q   <= '0;
            qe1_q  <= '0;
            neg1_q <= 1'b0;
            tag1_q <= '0;
        end else if (adv && in_valid_i) begin
            a1_q   <= a_i;
            qe1_q  <= qe1_d;
            neg1_q <= neg_i;
            tag1_q <= tag_in_i;
        end
    end

    // Stage 2: the true remainder is below 3Q, so RW bits of the wrapped difference suffice.
    logic [RW-1:0]    r2_d, r2_q;
    logic             neg2_q;
    logic [TAG_W-1:0] tag2_q;

    assign r2_d = RW'(XW'(a1_q) - XW'(qe1_q) * QX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r2_q   <= '0;
            neg2_q <= 1'b0;
            tag2_q <= '0;
        end else if (adv && v1_q) begin
            r2_q   <= r2_d;
            neg2_q <= neg1_q;
            tag2_q <= tag1_q;
        end
    end

    // Stage 3: final correction into [0, Q) and optional negation; zero stays zero.
    logic [RW-1:0]    s3;
    logic [RW-1:0]    res3;
    logic [OUT_W-1:0] result_d, result_q;
    logic [TAG_W-1:0] tag3_q;
    logic             neg3_q;

    always_comb begin
        s3 = r2_q;
        if (r2_q >= Q2R) begin
            s3 = r2_q - Q2R;
        end else if (r2_q >= QR) begin
            s3 = r2_q - QR;
        end
        res3 = s3;
        if (neg2_q && (s3 != '0)) begin
            res3 = QR - s3;
        end
        result_d = OUT_W'(res3);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            tag3_q   <= '0;
            neg3_q   <= 1'b0;
        end else if (adv && v2_q) begin
            result_q <= result_d;
            tag3_q   <= tag2_q;
            neg3_q   <= neg2_q;
        end
    end

    assign result_o  = result_q;
    assign tag_out_o = tag3_q;
    assign out_neg_o = neg3_q;

endmodule
